// File: rtl/bias_relu_requant.sv
// Output stage: bias add on the first of N_PASS beats, saturating accumulate, ReLU, shift and
// unsigned saturation into a valid/ready register. Define ROUND_EN to round half up before the shift.
module bias_relu_requant #(
  parameter int N_adder_tree = 16,
  parameter int IN_W         = 18,
  parameter int ACC_W        = 24,
  parameter int N_PASS       = 4,
  parameter int SHIFT        = 6,
  parameter int OUT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_adder_tree*IN_W-1:0]  bias,
  input  logic [N_adder_tree*IN_W-1:0]  in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_adder_tree*OUT_W-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int SW    = ((ACC_W > IN_W) ? ACC_W : IN_W) + 2;
  localparam int QW    = ACC_W + 1;
  localparam int CNT_W = (N_PASS > 1) ? $clog2(N_PASS) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_PASS - 1);
  localparam logic [CNT_W-1:0]     ZERO_CNT = {CNT_W{1'b0}};
  localparam logic signed [SW-1:0] ACC_MAX  = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] ACC_MIN  = SW'(-(64'sd1 <<< (ACC_W - 1)));
  localparam logic [QW-1:0]        OUT_MAX  = QW'((64'd1 << OUT_W) - 64'd1);
`ifdef ROUND_EN
  localparam logic [QW-1:0]        HALF_LSB = QW'(64'd1 << (SHIFT - 1));
`endif

  logic signed [ACC_W-1:0]         acc_q [N_adder_tree];
  logic signed [ACC_W-1:0]         acc_d [N_adder_tree];
  logic [CNT_W-1:0]                pass_cnt_q, pass_cnt_d;
  logic [N_adder_tree*OUT_W-1:0]   out_data_q, out_data_d, requant_s;
  logic                            out_valid_q, out_valid_d;
  logic                            last_beat_s, accept_s;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[ACC_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  // Only the last beat of a group needs the output register to be free.
  assign last_beat_s = (pass_cnt_q == LAST_CNT);
  assign in_ready    = !last_beat_s || !out_valid_q || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (pass_cnt_q != ZERO_CNT) || out_valid_q;

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    logic signed [IN_W-1:0]  data_s, bias_s;
    logic signed [SW-1:0]    base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [QW-1:0]           relu_s, q_s;

    assign data_s = in_data[g*IN_W +: IN_W];
    assign bias_s = bias[g*IN_W +: IN_W];
    assign base_s = (pass_cnt_q == ZERO_CNT) ? SW'(bias_s) : SW'(acc_q[g]);
    assign sum_s  = sat_acc(SW'(data_s) + base_s);
    assign relu_s = sum_s[ACC_W-1] ? {QW{1'b0}} : {1'b0, sum_s};
`ifdef ROUND_EN
    assign q_s    = (relu_s + HALF_LSB) >> SHIFT;
`else
    assign q_s    = relu_s >> SHIFT;
`endif
    assign requant_s[g*OUT_W +: OUT_W] = (q_s > OUT_MAX) ? {OUT_W{1'b1}} : q_s[OUT_W-1:0];
    assign acc_d[g] = accept_s ? sum_s : acc_q[g];
  end

  // Next state of beat counter and output register; a last beat may replace a draining result.
  always_comb begin
    pass_cnt_d  = pass_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept_s) begin
      if (last_beat_s) begin
        pass_cnt_d = ZERO_CNT;
      end else begin
        pass_cnt_d = pass_cnt_q + CNT_W'(1'b1);
      end
    end else begin
      pass_cnt_d = pass_cnt_q;
    end
    if (accept_s && last_beat_s) begin
      out_data_d  = requant_s;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_adder_tree; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
      end
      pass_cnt_q  <= ZERO_CNT;
      out_data_q  <= {(N_adder_tree*OUT_W){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_adder_tree; i++) begin
        acc_q[i] <= acc_d[i];
      end
      pass_cnt_q  <= pass_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bias_relu_requant.sv
// Scoreboard bench: default instance, an ACC_W=20 twin sharing its stimulus, and an N_PASS=1 instance.
module tb_bias_relu_requant;
  localparam int N = 16, IW = 18, OW = 8, NP = 4, SHIFT = 6;
  localparam int BW = N*IW, OBW = N*OW;
`ifdef ROUND_EN
  localparam int EXP_A = 11;
`else
  localparam int EXP_A = 10;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic [BW-1:0] bias = '0, in_data = '0, bias1 = '0, in_data1 = '0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic in_ready, out_valid, busy, in_ready_b, out_valid_b, busy_b, in_ready1, out_valid1, busy1;
  logic [OBW-1:0] out_data, out_data_b, out_data1;

  bias_relu_requant #(.N_adder_tree(N), .IN_W(IW), .ACC_W(24), .N_PASS(NP), .SHIFT(SHIFT), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy));
  bias_relu_requant #(.N_adder_tree(N), .IN_W(IW), .ACC_W(20), .N_PASS(NP), .SHIFT(SHIFT), .OUT_W(OW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b));
  bias_relu_requant #(.N_adder_tree(N), .IN_W(IW), .ACC_W(24), .N_PASS(1), .SHIFT(SHIFT), .OUT_W(OW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bias(bias1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [OBW-1:0] q24[$], q20[$], q1[$];
  longint macc24[N], macc20[N];
  int mcnt = 0;
  bit lat_flag = 1'b0, lat_flag1 = 1'b0;

  task automatic check(input string name, input logic [OBW-1:0] got, input logic [OBW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkn(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    else if (v < mn) return mn;
    else return v;
  endfunction

  function automatic int requant(input longint s);
    longint r;
    r = (s < 0) ? 0 : s;
`ifdef ROUND_EN
    r = r + (longint'(1) <<< (SHIFT - 1));
`endif
    r = r / (longint'(1) <<< SHIFT);
    return (r > 255) ? 255 : int'(r);
  endfunction

  function automatic longint lane_val(input logic [BW-1:0] v, input int i);
    logic signed [IW-1:0] t;
    t = v[i*IW +: IW];
    return longint'(t);
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] v, input int lane, input int val);
    v[lane*IW +: IW] = IW'(val);
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_vec(input bit is_bias);
    logic [BW-1:0] v;
    int val;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) val = int'($urandom);
      else if (is_bias) val = int'($urandom_range(0, 9000)) - 3000;
      else val = int'($urandom_range(0, 4000)) - 2000;
      v = put(v, i, val);
    end
    return v;
  endfunction

  // Reference: group-level arithmetic on the accepted beats, for both accumulator widths.
  task automatic record(input logic [BW-1:0] d, input logic [BW-1:0] b);
    logic [OBW-1:0] e24, e20;
    longint dv, bv;
    e24 = '0;
    e20 = '0;
    for (int i = 0; i < N; i++) begin
      dv = lane_val(d, i);
      bv = lane_val(b, i);
      if (mcnt == 0) begin
        macc24[i] = sat(bv + dv, 24);
        macc20[i] = sat(bv + dv, 20);
      end else begin
        macc24[i] = sat(macc24[i] + dv, 24);
        macc20[i] = sat(macc20[i] + dv, 20);
      end
      e24[i*OW +: OW] = OW'(requant(macc24[i]));
      e20[i*OW +: OW] = OW'(requant(macc20[i]));
    end
    mcnt++;
    if (mcnt == NP) begin
      q24.push_back(e24);
      q20.push_back(e20);
      mcnt = 0;
      lat_flag = 1'b1;
    end
  endtask

  task automatic beat(input logic [BW-1:0] d, input logic rdy);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    out_ready = rdy;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      if (n >= 2) out_ready = 1'b1;
      #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: in_ready %0d after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      record(d, bias);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic idle(input logic rdy);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = rdy;
  endtask

  // Monitor for the N_PASS=4 pair.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (lat_flag) begin
        checkn("latency_valid", out_valid, 1);
        lat_flag = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q24.size() == 0) begin
          checkn("unexpected_output", 1, 0);
        end else begin
          check("data_acc24", out_data, q24.pop_front());
          check("data_acc20", out_data_b, q20.pop_front());
          checkn("valid_acc20", out_valid_b, 1);
        end
      end
    end
  end

  // Monitor for the N_PASS=1 instance.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (lat_flag1) begin
        checkn("np1_latency_valid", out_valid1, 1);
        lat_flag1 = 1'b0;
      end
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) checkn("np1_unexpected_output", 1, 0);
        else check("np1_data", out_data1, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] d, db4;
    logic [OBW-1:0] e1;

    #2 rst_n = 1'b0;
    #10;
    checkn("rst_out_valid", out_valid, 0);
    checkn("rst_busy", busy, 0);
    check("rst_out_data", out_data, '0);
    checkn("rst_in_ready", in_ready, 1);
    checkn("rst_np1_out_valid", out_valid1, 0);
    @(negedge clk) rst_n = 1'b1;

    // Bias once, then ReLU on a negative lane.
    bias = put(put('0, 0, 272), 1, -6232);
    d = put(put('0, 0, 100), 1, 1000);
    repeat (4) beat(d, 1'b1);
    @(negedge clk) #3;
    checkn("grp1_valid", out_valid, 1);
    checkn("grp1_lane0", out_data[0 +: 8], EXP_A);
    checkn("grp1_lane1_relu", out_data[8 +: 8], 0);
    @(negedge clk) #3;
    checkn("grp1_valid_one_cycle", out_valid, 0);

    // Output saturation and accumulator saturation (ACC_W=20) in both directions.
    bias = put(put(put('0, 0, 272), 2, 131071), 3, -131072);
    d = put(put(put('0, 0, 20000), 2, 131071), 3, -131072);
    repeat (4) beat(d, 1'b1);
    @(negedge clk) #3;
    checkn("sat_lane0", out_data[0 +: 8], 255);
    checkn("sat_acc20_pos", out_data_b[16 +: 8], 255);
    checkn("sat_acc20_neg", out_data_b[24 +: 8], 0);
    repeat (2) idle(1'b1);

    // Stall: group B accumulates while group A's result waits.
    bias = rand_vec(1'b1);
    repeat (4) beat(rand_vec(1'b0), 1'b0);
    repeat (3) beat(rand_vec(1'b0), 1'b0);
    db4 = rand_vec(1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = db4;
    out_ready = 1'b0;
    #1;
    checkn("stall_in_ready", in_ready, 0);
    checkn("stall_busy", busy, 1);
    checkn("stall_valid", out_valid, 1);
    check("stall_hold_data", out_data, q24[0]);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkn("release_in_ready", in_ready, 1);
    @(posedge clk);
    record(db4, bias);
    #1 in_valid = 1'b0;
    repeat (2) idle(1'b1);

    // Asynchronous reset mid-group with a pending output.
    bias = rand_vec(1'b1);
    repeat (4) beat(rand_vec(1'b0), 1'b0);
    repeat (2) beat(rand_vec(1'b0), 1'b0);
    @(negedge clk) #3;
    checkn("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkn("mid_rst_valid", out_valid, 0);
    checkn("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_data_acc20", out_data_b, '0);
    q24.delete();
    q20.delete();
    mcnt = 0;
    lat_flag = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bias = rand_vec(1'b1);
    repeat (4) beat(rand_vec(1'b0), 1'b1);

    // Randomised groups with random gaps and back-pressure.
    for (int g = 0; g < 50; g++) begin
      bias = rand_vec(1'b1);
      for (int b = 0; b < NP; b++) begin
        if ($urandom_range(0, 2) == 0) idle(logic'($urandom_range(0, 1)));
        beat(rand_vec(1'b0), logic'($urandom_range(0, 3) != 0));
      end
    end
    repeat (8) idle(1'b1);
    checkn("drain_empty", q24.size(), 0);

    // N_PASS=1: back-to-back results at full rate.
    bias1 = rand_vec(1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid1 = 1'b1;
      in_data1 = rand_vec(1'b0);
      out_ready1 = 1'b1;
      #1;
      checkn("np1_in_ready", in_ready1, 1);
      @(posedge clk);
      e1 = '0;
      for (int i = 0; i < N; i++)
        e1[i*OW +: OW] = OW'(requant(sat(lane_val(bias1, i) + lane_val(in_data1, i), 24)));
      q1.push_back(e1);
      lat_flag1 = 1'b1;
    end
    @(negedge clk) in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    checkn("np1_drain_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
